cby_param_cfg: RTL and testbench

Parametrised Y-channel connection block with an integrated serial configuration loader. It passes `CHAN_W` vertical tracks straight through in both directions and drives `NUM_IPIN` grid input pins, each from a `MUX_SIZE`-input routing mux. Each mux is selected by an encoded code held in an active register bank. A shift chain loads a shadow bank, and a commit handshake copies it into the active bank in one cycle, so routing never sees a partially loaded configuration. The block sits in the routing fabric between the switch blocks above and below it and the grid tiles to its left and right.

---
 rtl/cby_param_cfg.sv | 173 +++++++++++++++++
 tb/tb_cby_param_cfg.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cby_param_cfg.sv
// cby_param_cfg: Y-channel connection block with a serial configuration loader.
//
// Vertical tracks pass straight through in both directions. Each of NUM_IPIN grid
// pins is driven by a MUX_SIZE-input mux whose encoded select code lives in an
// active register bank. A shift chain fills a shadow bank; a commit copies the
// whole shadow bank into the active bank in one edge, so routing never sees a
// partially loaded configuration.
//
// Ports:
//   prog_clk, pReset          clock, synchronous active-high reset
//   chany_bottom_in/top_in    tracks entering from below / above
//   chany_top_out/bottom_out  combinational pass-through of the opposite input
//   ipin_out                  grid pin drivers (combinational from tracks)
//   cfg_start                 begin (or restart) a chain load
//   ccff_en, ccff_head        shift enable and serial data in
//   ccff_tail                 serial data out (last shadow bit)
//   cfg_commit                copy shadow into active while armed
//   cfg_busy, cfg_armed       loader in LOAD / ARMED
//   cfg_done                  one-cycle pulse after a commit
//   cfg_err                   sticky: an out-of-range select code was committed
module cby_param_cfg #(
    parameter int unsigned CHAN_W   = 9,
    parameter int unsigned NUM_IPIN = 10,
    parameter int unsigned MUX_SIZE = 6,
    parameter int unsigned TAP_STEP = 4,
    parameter int unsigned SEL_W    = $clog2(MUX_SIZE + 1),
    parameter int unsigned TOTAL    = NUM_IPIN * SEL_W
) (
    input  logic                prog_clk,
    input  logic                pReset,
    input  logic [CHAN_W-1:0]   chany_bottom_in,
    input  logic [CHAN_W-1:0]   chany_top_in,
    output logic [CHAN_W-1:0]   chany_top_out,
    output logic [CHAN_W-1:0]   chany_bottom_out,
    output logic [NUM_IPIN-1:0] ipin_out,
    input  logic                cfg_start,
    input  logic                ccff_en,
    input  logic                ccff_head,
    output logic                ccff_tail,
    input  logic                cfg_commit,
    output logic                cfg_busy,
    output logic                cfg_armed,
    output logic                cfg_done,
    output logic                cfg_err
);

    localparam int unsigned CNT_W = $clog2(TOTAL + 1);

    typedef enum logic [1:0] {StIdle, StLoad, StArmed} state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [TOTAL-1:0]   shadow_q;
    logic [TOTAL-1:0]   active_q;
    logic               done_q;
    logic               err_q;

    logic               do_shift;
    logic               do_clear;
    logic               do_commit;
    logic [NUM_IPIN-1:0] code_bad;
    logic [NUM_IPIN*MUX_SIZE-1:0] mux_in;

    // Pass-through tracks.
    assign chany_top_out    = chany_bottom_in;
    assign chany_bottom_out = chany_top_in;

    // State register.
    always_ff @(posedge prog_clk) begin
        if (pReset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. cfg_start wins over everything else in every state.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (cfg_start) state_d = StLoad;
            end
            StLoad: begin
                if (cfg_start) begin
                    state_d = StLoad;
                end else if (ccff_en && (cnt_q == CNT_W'(TOTAL - 1))) begin
                    state_d = StArmed;
                end
            end
            StArmed: begin
                if (cfg_start) begin
                    state_d = StLoad;
                end else if (cfg_commit) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs and datapath strobes decoded from the current state.
    always_comb begin
        cfg_busy  = (state_q == StLoad);
        cfg_armed = (state_q == StArmed);
        do_clear  = cfg_start;
        do_shift  = (state_q == StLoad) && ccff_en && !cfg_start;
        do_commit = (state_q == StArmed) && cfg_commit && !cfg_start;
    end

    // Configuration datapath.
    always_ff @(posedge prog_clk) begin
        if (pReset) begin
            cnt_q    <= '0;
            shadow_q <= '0;
            active_q <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            if (do_clear) begin
                cnt_q <= '0;
            end else if (do_shift) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
            if (do_shift) begin
                shadow_q <= {shadow_q[TOTAL-2:0], ccff_head};
            end
            if (do_commit) begin
                active_q <= shadow_q;
            end
            done_q <= do_commit;
            if (do_commit && (|code_bad)) begin
                err_q <= 1'b1;
            end
        end
    end

    assign ccff_tail = shadow_q[TOTAL-1];
    assign cfg_done  = done_q;
    assign cfg_err   = err_q;

    // Per-pin mux wiring and decode.
    for (genvar p = 0; p < NUM_IPIN; p++) begin : g_pin
        logic [SEL_W-1:0] act_code;
        logic [SEL_W-1:0] shd_code;
        logic             pin_val;

        // Input pair k taps track p + k*TAP_STEP; even inputs from below, odd from above.
        for (genvar j = 0; j < MUX_SIZE; j++) begin : g_in
            localparam int unsigned Trk = (p + (j / 2) * TAP_STEP) % CHAN_W;
            if ((j % 2) == 0) begin : g_bot
                assign mux_in[p*MUX_SIZE+j] = chany_bottom_in[Trk];
            end else begin : g_top
                assign mux_in[p*MUX_SIZE+j] = chany_top_in[Trk];
            end
        end

        assign act_code    = active_q[p*SEL_W +: SEL_W];
        assign shd_code    = shadow_q[p*SEL_W +: SEL_W];
        assign code_bad[p] = (shd_code > SEL_W'(MUX_SIZE));

        // Code 0 and codes above MUX_SIZE leave the pin off.
        always_comb begin
            pin_val = 1'b0;
            for (int j = 0; j < MUX_SIZE; j++) begin
                if (act_code == SEL_W'(j + 1)) pin_val = mux_in[p*MUX_SIZE+j];
            end
        end

        assign ipin_out[p] = pin_val;
    end

endmodule

// File: tb/tb_cby_param_cfg.sv
// Scoreboard bench for cby_param_cfg with default parameters.
module tb_cby_param_cfg;

    logic       prog_clk = 1'b0;
    logic       pReset = 1'b0;
    logic [8:0] chany_bottom_in = '0;
    logic [8:0] chany_top_in = '0;
    logic [8:0] chany_top_out;
    logic [8:0] chany_bottom_out;
    logic [9:0] ipin_out;
    logic       cfg_start = 1'b0;
    logic       ccff_en = 1'b0;
    logic       ccff_head = 1'b0;
    logic       ccff_tail;
    logic       cfg_commit = 1'b0;
    logic       cfg_busy;
    logic       cfg_armed;
    logic       cfg_done;
    logic       cfg_err;

    cby_param_cfg dut (
        .prog_clk        (prog_clk),
        .pReset          (pReset),
        .chany_bottom_in (chany_bottom_in),
        .chany_top_in    (chany_top_in),
        .chany_top_out   (chany_top_out),
        .chany_bottom_out(chany_bottom_out),
        .ipin_out        (ipin_out),
        .cfg_start       (cfg_start),
        .ccff_en         (ccff_en),
        .ccff_head       (ccff_head),
        .ccff_tail       (ccff_tail),
        .cfg_commit      (cfg_commit),
        .cfg_busy        (cfg_busy),
        .cfg_armed       (cfg_armed),
        .cfg_done        (cfg_done),
        .cfg_err         (cfg_err)
    );

    always #5 prog_clk = ~prog_clk;

    // Config words: code for pin p sits in bits [3p+2:3p].
    localparam logic [29:0] W1 = 30'h0000_0021;  // pin0=1, pin1=4
    localparam logic [29:0] W2 = 30'h3000_0080;  // pin9=6, pin2=2
    localparam logic [29:0] W3 = 30'h0000_3E00;  // pin3=7 (illegal), pin4=3

    typedef struct {
        string      name;
        logic [8:0] top;
        logic [8:0] bot;
        logic [9:0] ipin;
        logic       tail;
        logic       busy;
        logic       armed;
        logic       done;
        logic       err;
    } exp_t;

    typedef struct {
        string      name;
        logic [9:0] ipin;
        logic       err;
    } done_t;

    exp_t  exp_q[$];
    done_t done_q[$];
    exp_t  e;
    done_t d;
    logic  chk_req = 1'b0;
    int    total = 0;
    int    bad = 0;

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, req);
        end
    endtask

    // Monitor: checkpoint snapshots and commit-done events.
    always @(negedge prog_clk) begin
        if (chk_req) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL checkpoint: got no expectation expected one queued");
            end else begin
                e = exp_q.pop_front();
                cmp({e.name, ".top_out"}, 32'(chany_top_out), 32'(e.top));
                cmp({e.name, ".bottom_out"}, 32'(chany_bottom_out), 32'(e.bot));
                cmp({e.name, ".ipin"}, 32'(ipin_out), 32'(e.ipin));
                cmp({e.name, ".tail"}, 32'(ccff_tail), 32'(e.tail));
                cmp({e.name, ".busy"}, 32'(cfg_busy), 32'(e.busy));
                cmp({e.name, ".armed"}, 32'(cfg_armed), 32'(e.armed));
                cmp({e.name, ".done"}, 32'(cfg_done), 32'(e.done));
                cmp({e.name, ".err"}, 32'(cfg_err), 32'(e.err));
            end
        end
        if (cfg_done === 1'b1) begin
            if (done_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done: got cfg_done=1 expected 0");
            end else begin
                d = done_q.pop_front();
                cmp({d.name, ".ipin"}, 32'(ipin_out), 32'(d.ipin));
                cmp({d.name, ".err"}, 32'(cfg_err), 32'(d.err));
            end
        end
    end

    task automatic tick();
        @(posedge prog_clk);
        #1;
    endtask

    task automatic cp(input string nm, input logic [9:0] ipin, input logic tail,
                      input logic busy, input logic armed, input logic done, input logic err);
        exp_t r;
        r.name  = nm;
        r.top   = chany_bottom_in;
        r.bot   = chany_top_in;
        r.ipin  = ipin;
        r.tail  = tail;
        r.busy  = busy;
        r.armed = armed;
        r.done  = done;
        r.err   = err;
        exp_q.push_back(r);
        chk_req = 1'b1;
        @(negedge prog_clk);
        #1;
        chk_req = 1'b0;
    endtask

    task automatic start_pulse();
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
    endtask

    // Shift n bits of w, MSB-first starting at index hi; optional random stalls.
    task automatic shift_n(input logic [29:0] w, input int hi, input int n, input bit stall);
        for (int i = 0; i < n; i++) begin
            if (stall) begin
                int gaps;
                gaps = $urandom_range(0, 3);
                for (int g = 0; g < gaps; g++) begin
                    ccff_en   = 1'b0;
                    ccff_head = 1'($urandom_range(0, 1));
                    tick();
                end
            end
            ccff_en   = 1'b1;
            ccff_head = w[hi-i];
            tick();
        end
        ccff_en   = 1'b0;
        ccff_head = 1'b0;
    endtask

    task automatic commit(input string nm, input logic [9:0] ipin, input logic err);
        done_t r;
        r.name = nm;
        r.ipin = ipin;
        r.err  = err;
        done_q.push_back(r);
        cfg_commit = 1'b1;
        tick();
        cfg_commit = 1'b0;
        tick();
    endtask

    initial begin
        // Reset and idle behaviour.
        chany_bottom_in = 9'h1A5;
        chany_top_in    = 9'h0F3;
        pReset = 1'b1;
        tick();
        tick();
        pReset = 1'b0;
        cp("reset", 10'h000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        ccff_en = 1'b1;
        ccff_head = 1'b1;
        cfg_commit = 1'b1;
        tick();
        tick();
        tick();
        ccff_en = 1'b0;
        ccff_head = 1'b0;
        cfg_commit = 1'b0;
        cp("idle_ignore", 10'h000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Basic load: pin0 <- bottom[0], pin1 <- top[5].
        start_pulse();
        cp("load_busy", 10'h000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        shift_n(W1, 29, 30, 1'b0);
        cp("armed1", 10'h000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        done_q.push_back('{name: "commit1", ipin: 10'h003, err: 1'b0});
        cfg_commit = 1'b1;
        tick();
        cfg_commit = 1'b0;
        cp("done_high", 10'h003, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        cp("done_low", 10'h003, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chany_bottom_in = 9'h1A4;
        chany_top_in    = 9'h0D3;
        cp("follow", 10'h000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Stalled load; routing holds the old config until commit.
        chany_bottom_in = 9'h1A5;
        chany_top_in    = 9'h104;
        start_pulse();
        shift_n(W2, 29, 29, 1'b1);
        cp("stall_29", 10'h001, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        shift_n(W2, 0, 1, 1'b1);
        cp("stall_armed", 10'h001, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        commit("commit2", 10'h204, 1'b0);
        cp("after2", 10'h204, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

        // Restart at shift 17, then start beats commit in ARMED.
        start_pulse();
        shift_n(W3, 29, 17, 1'b0);
        cfg_start = 1'b1;
        ccff_en = 1'b1;
        ccff_head = 1'b1;
        tick();
        cfg_start = 1'b0;
        ccff_en = 1'b0;
        ccff_head = 1'b0;
        cp("restart", 10'h204, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        shift_n(W3, 29, 29, 1'b0);
        cp("restart_29", 10'h204, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        shift_n(W3, 0, 1, 1'b0);
        cp("restart_armed", 10'h204, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        cfg_start = 1'b1;
        cfg_commit = 1'b1;
        tick();
        cfg_start = 1'b0;
        cfg_commit = 1'b0;
        cp("start_beats_commit", 10'h204, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

        // Illegal code on pin3 sets the sticky error.
        shift_n(W3, 29, 30, 1'b0);
        commit("commit_err", 10'h010, 1'b1);
        cp("err_set", 10'h010, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        start_pulse();
        shift_n(W1, 29, 30, 1'b0);
        commit("commit_clean", 10'h001, 1'b1);
        cp("err_sticky", 10'h001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        // Reset mid-LOAD and in ARMED (with a competing commit).
        start_pulse();
        shift_n(W2, 29, 10, 1'b0);
        pReset = 1'b1;
        tick();
        pReset = 1'b0;
        cp("rst_load", 10'h000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        start_pulse();
        shift_n(W2, 29, 30, 1'b0);
        cp("armed_pre_rst", 10'h000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        pReset = 1'b1;
        cfg_commit = 1'b1;
        tick();
        pReset = 1'b0;
        cfg_commit = 1'b0;
        cp("rst_armed", 10'h000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Chain passthrough; extra shifts in ARMED are ignored.
        start_pulse();
        shift_n(W2, 29, 30, 1'b0);
        ccff_en = 1'b1;
        ccff_head = 1'b0;
        tick();
        tick();
        ccff_en = 1'b0;
        cp("passthru", 10'h000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        commit("commit_final", 10'h204, 1'b0);
        cp("final", 10'h204, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

        tick();
        tick();
        if (exp_q.size() != 0 || done_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL leftover: got %0d checkpoints and %0d dones pending expected 0",
                     exp_q.size(), done_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish within 200000");
        $fatal(1);
    end

endmodule
